// File: rtl/hier_include_resp.sv
// Request/acknowledge responder: queues requests in a FIFO and serves them one at a time,
// returning payload+1 tagged with a sequence number. Optional macro: HIER_INCLUDE_RESP_STATS_EN.

package hierIncludeTop_package;
    parameter int ANOTHER_SIZE = 4;
endpackage

//  state | meaning
//  IDLE  | waiting for a queued request; pops the FIFO head into the working register
//  BUSY  | service timer counting down to terminal count
//  RESP  | acknowledge presented, held until ack_rdy
module hier_include_resp
    import hierIncludeTop_package::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = ANOTHER_SIZE,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_rdy,
    output logic             ack_vld,
    output logic [WIDTH-1:0] ack_data,
    output logic [1:0]       ack_tag,
    input  logic             ack_rdy
`ifdef HIER_INCLUDE_RESP_STATS_EN
    ,
    output logic [15:0]      resp_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             ack_vld_nxt;
    logic [WIDTH-1:0] ack_data_nxt;
    logic [1:0]       seq;
    logic [1:0]       seq_nxt;

    // Ready comes from registered occupancy only, so it never combinationally follows req_vld.
    assign req_rdy = (occ != OW'(DEPTH));
    assign push    = req_vld & req_rdy;
    assign ack_tag = seq;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            work     <= '0;
            ack_vld  <= 1'b0;
            ack_data <= '0;
            seq      <= 2'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            work     <= work_nxt;
            ack_vld  <= ack_vld_nxt;
            ack_data <= ack_data_nxt;
            seq      <= seq_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        work_nxt     = work;
        ack_vld_nxt  = ack_vld;
        ack_data_nxt = ack_data;
        seq_nxt      = seq;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (occ != '0) begin
                    pop       = 1'b1;
                    work_nxt  = mem[rd_ptr];
                    cnt_nxt   = CW'(LATENCY - 1);
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    ack_vld_nxt  = 1'b1;
                    ack_data_nxt = work + WIDTH'(1);
                    state_nxt    = ST_RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_RESP: begin
                if (ack_rdy) begin
                    ack_vld_nxt = 1'b0;
                    seq_nxt     = seq + 2'd1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                ack_vld_nxt = 1'b0;
            end
        endcase
    end

`ifdef HIER_INCLUDE_RESP_STATS_EN
    // Saturating count of completed handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_count <= 16'h0000;
        end else if (ack_vld && ack_rdy && (resp_count != 16'hFFFF)) begin
            resp_count <= resp_count + 16'h0001;
        end
    end
`endif

endmodule
